// File: rtl/uart_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_packetizer
// Purpose  : Buffers 32-bit words in a FIFO and frames each one as a byte
//            packet (header, 4 data bytes LSB first, optional XOR checksum),
//            paced by the UART transmitter's active/done flags.
//            Define UART_TX_PKT_CHECKSUM_EN to append the checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_packetizer #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic [31:0]                 i_Word,
    input  logic                        i_Word_Valid,
    output logic                        o_Word_Ready,
    output logic                        o_Tx_DV,
    output logic [7:0]                  o_Tx_Byte,
    input  logic                        i_Tx_Active,
    input  logic                        i_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Busy,
    output logic                        o_Pkt_Done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PKT_CHECKSUM_EN
    localparam logic [2:0] c_LAST_IDX = 3'd5;
`else
    localparam logic [2:0] c_LAST_IDX = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_WAIT_CLR  = 2'd3
    } state_t;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_advance;
    logic             w_last_done;
    logic [2:0]       r_index;
    logic [31:0]      r_word;
    logic [7:0]       w_cur_byte;
    logic             r_tx_dv;
    logic [7:0]       r_tx_byte;
    logic             r_busy;
    logic             r_pkt_done;

    // Ready depends only on the count register, so a same-cycle pop never frees a slot early
    assign o_Word_Ready = (r_count < c_DEPTH);
    assign o_Fifo_Count = r_count;
    assign w_push       = i_Word_Valid && o_Word_Ready;

    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Word;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // WAIT_CLR waits out the transmitter's done/cleanup tail before the next byte
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_advance    = 1'b0;
        w_last_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !i_Tx_Active && !i_Tx_Done) begin
                    w_pop        = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) w_next_state = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!i_Tx_Done && !i_Tx_Active) begin
                    if (r_index == c_LAST_IDX) begin
                        w_last_done  = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = S_SEND;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_PKT_CHECKSUM_EN
    logic [31:0] w_head_word;
    logic [7:0]  r_checksum;

    assign w_head_word = r_mem[r_rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= w_head_word[7:0] ^ w_head_word[15:8] ^
                          w_head_word[23:16] ^ w_head_word[31:24];
        end
    end
`endif

    always_comb begin
        w_cur_byte = HEADER;
        case (r_index)
            3'd1:    w_cur_byte = r_word[7:0];
            3'd2:    w_cur_byte = r_word[15:8];
            3'd3:    w_cur_byte = r_word[23:16];
            3'd4:    w_cur_byte = r_word[31:24];
`ifdef UART_TX_PKT_CHECKSUM_EN
            3'd5:    w_cur_byte = r_checksum;
`endif
            default: w_cur_byte = HEADER;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_index    <= '0;
            r_word     <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= '0;
            r_busy     <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_tx_dv    <= (r_state == S_SEND);
            r_busy     <= (w_next_state != S_IDLE);
            r_pkt_done <= w_last_done;
            if (r_state == S_SEND) begin
                r_tx_byte <= w_cur_byte;
            end
            if (w_pop) begin
                r_word  <= r_mem[r_rd_ptr];
                r_index <= '0;
            end else if (w_advance) begin
                r_index <= r_index + 3'd1;
            end
        end
    end

    assign o_Tx_DV    = r_tx_dv;
    assign o_Tx_Byte  = r_tx_byte;
    assign o_Busy     = r_busy;
    assign o_Pkt_Done = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_packetizer
// Purpose  : Self-checking bench for uart_tx_packetizer with a transmitter
//            model and a word-level reference of the expected byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_packetizer;

    localparam int c_DEPTH = 8;
`ifdef UART_TX_PKT_CHECKSUM_EN
    localparam int c_PKT_LEN = 6;
`else
    localparam int c_PKT_LEN = 5;
`endif

    logic        clk = 1'b0;
    logic        i_Reset;
    logic [31:0] i_Word;
    logic        i_Word_Valid;
    logic        o_Word_Ready;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic [3:0]  o_Fifo_Count;
    logic        o_Busy;
    logic        o_Pkt_Done;

    logic        stall;
    logic        model_act;
    logic        model_done;
    logic        tx_active;
    logic        tx_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pkt_cnt  = 0;
    int          act_left = 0;
    int          done_left = 0;
    int unsigned act_min = 3, act_max = 3, done_min = 2, done_max = 2;
    logic [7:0]  cap_q[$];
    logic [31:0] ref_words[$];

    typedef struct {
        logic [31:0] word;
        logic [7:0]  bytes [6];
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    assign tx_active = stall | model_act;
    assign tx_done   = model_done;

    uart_tx_packetizer #(
        .FIFO_DEPTH (c_DEPTH),
        .HEADER     (8'hA5)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (i_Reset),
        .i_Word       (i_Word),
        .i_Word_Valid (i_Word_Valid),
        .o_Word_Ready (o_Word_Ready),
        .o_Tx_DV      (o_Tx_DV),
        .o_Tx_Byte    (o_Tx_Byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (tx_done),
        .o_Fifo_Count (o_Fifo_Count),
        .o_Busy       (o_Busy),
        .o_Pkt_Done   (o_Pkt_Done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: busy for a few cycles per byte, then done for a few more
    initial begin : tx_model
        model_act  = 1'b0;
        model_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_Tx_DV) begin
                check("dv_while_tx_busy", {31'd0, (tx_active | tx_done)}, 32'd0);
            end
            if (model_done) begin
                done_left--;
                if (done_left <= 0) model_done = 1'b0;
            end
            if (model_act) begin
                act_left--;
                if (act_left <= 0) begin
                    model_act  = 1'b0;
                    model_done = 1'b1;
                    done_left  = int'($urandom_range(done_max, done_min));
                end
            end
            if (o_Tx_DV) begin
                cap_q.push_back(o_Tx_Byte);
                model_act = 1'b1;
                act_left  = int'($urandom_range(act_max, act_min));
            end
            if (o_Pkt_Done) begin
                pkt_cnt++;
                check("pkt_done_on_boundary", cap_q.size() % c_PKT_LEN, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic push_word(input logic [31:0] w);
        int   t   = 0;
        logic acc = 1'b0;
        i_Word       = w;
        i_Word_Valid = 1'b1;
        while (!acc && t < 5000) begin
            acc = o_Word_Ready;
            @(posedge clk);
            #1;
            t++;
        end
        i_Word_Valid = 1'b0;
        check("push_accepted", {31'd0, acc}, 32'd1);
        if (acc) ref_words.push_back(w);
    endtask

    task automatic wait_pkts(input int target);
        int t = 0;
        while (pkt_cnt < target && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("pkt_wait_in_time", {31'd0, (pkt_cnt >= target)}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: every accepted word becomes header, 4 bytes LSB first, optional XOR
    task automatic compare_stream(input string tag);
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        foreach (ref_words[k]) begin
            w = ref_words[k];
            exp_q.push_back(8'hA5);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
`ifdef UART_TX_PKT_CHECKSUM_EN
            exp_q.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
        end
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            check({tag, "_byte"}, {24'd0, cap_q[k]}, {24'd0, exp_q[k]});
        end
        check({tag, "_pkts"}, pkt_cnt, ref_words.size());
        cap_q.delete();
        ref_words.delete();
        pkt_cnt = 0;
    endtask

    initial begin : main
        int t;

        tbl[0].word = 32'h12345678; tbl[0].bytes = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        tbl[1].word = 32'h000000FF; tbl[1].bytes = '{8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        tbl[2].word = 32'hDEADBEEF; tbl[2].bytes = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        tbl[3].word = 32'h80402010; tbl[3].bytes = '{8'hA5, 8'h10, 8'h20, 8'h40, 8'h80, 8'hF0};
        tbl[4].word = 32'hFFFFFFFF; tbl[4].bytes = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};

        i_Reset      = 1'b1;
        i_Word       = '0;
        i_Word_Valid = 1'b0;
        stall        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_dv",   {31'd0, o_Tx_DV},      32'd0);
        check("rst_tx_byte", {24'd0, o_Tx_Byte},    32'd0);
        check("rst_ready",   {31'd0, o_Word_Ready}, 32'd1);
        check("rst_count",   {28'd0, o_Fifo_Count}, 32'd0);
        check("rst_busy",    {31'd0, o_Busy},       32'd0);
        check("rst_pkt_done",{31'd0, o_Pkt_Done},   32'd0);
        i_Reset = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: one word at a time, latency and bytes against fixed packets
        for (int i = 0; i < 5; i++) begin
            cap_q.delete();
            ref_words.delete();
            pkt_cnt = 0;
            push_word(tbl[i].word);
            @(posedge clk);
            #1;
            check("hdr_dv_not_yet", {31'd0, o_Tx_DV}, 32'd0);
            @(posedge clk);
            #1;
            check("hdr_dv_latency", {31'd0, o_Tx_DV}, 32'd1);
            check("hdr_byte_value", {24'd0, o_Tx_Byte}, 32'h0000_00A5);
            wait_pkts(1);
            check("tbl_len", cap_q.size(), c_PKT_LEN);
            for (int j = 0; j < c_PKT_LEN && j < cap_q.size(); j++) begin
                check("tbl_byte", {24'd0, cap_q[j]}, {24'd0, tbl[i].bytes[j]});
            end
            check("tbl_pkt_done_once", pkt_cnt, 32'd1);
        end
        cap_q.delete();
        ref_words.delete();
        pkt_cnt = 0;

        // Fill the FIFO against a stalled transmitter; the 9th word must wait
        stall = 1'b1;
        for (int i = 0; i < 8; i++) push_word(32'hA000_0000 + i);
        check("full_count", {28'd0, o_Fifo_Count}, 32'd8);
        check("full_ready", {31'd0, o_Word_Ready}, 32'd0);
        i_Word       = 32'hA000_0008;
        i_Word_Valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("full_held_count", {28'd0, o_Fifo_Count}, 32'd8);
        check("full_stalled_idle", {31'd0, o_Busy}, 32'd0);
        stall = 1'b0;
        push_word(32'hA000_0008);
        wait_pkts(9);
        compare_stream("fill_drain");

        // Reset while the third byte of a packet is in flight, three words queued
        for (int i = 0; i < 4; i++) push_word(32'hB000_0000 + i);
        t = 0;
        while (cap_q.size() < 3 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("mid_pkt_reached", {31'd0, (cap_q.size() >= 3)}, 32'd1);
        i_Reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_count", {28'd0, o_Fifo_Count}, 32'd0);
        check("mid_rst_busy",  {31'd0, o_Busy},       32'd0);
        check("mid_rst_dv",    {31'd0, o_Tx_DV},      32'd0);
        check("mid_rst_ready", {31'd0, o_Word_Ready}, 32'd1);
        i_Reset = 1'b0;
        cap_q.delete();
        ref_words.delete();
        pkt_cnt = 0;
        push_word(32'h0000_00FF);
        wait_pkts(1);
        compare_stream("after_reset");

        // Advance pointers so the following push/pop straddles the wrap point
        for (int i = 0; i < 6; i++) push_word(32'hC100_0000 + i);
        wait_pkts(6);
        compare_stream("prefill");

        stall = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'hC200_0000 + i);
        check("pp_count_before", {28'd0, o_Fifo_Count}, 32'd3);
        stall        = 1'b0;
        i_Word       = 32'hC200_0003;
        i_Word_Valid = 1'b1;
        @(posedge clk);
        #1;
        i_Word_Valid = 1'b0;
        ref_words.push_back(32'hC200_0003);
        check("pp_count_same", {28'd0, o_Fifo_Count}, 32'd3);
        check("pp_busy",       {31'd0, o_Busy},       32'd1);
        wait_pkts(4);
        compare_stream("push_pop_wrap");

        // Random words, random gaps, random transmitter busy/done lengths
        act_min = 1; act_max = 5; done_min = 1; done_max = 3;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(6, 0)) begin
                @(posedge clk);
                #1;
            end
            push_word($urandom);
        end
        wait_pkts(30);
        compare_stream("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_packetizer.md
# uart_tx_packetizer

Upstream feeder for the UART transmitter. Accepts 32-bit words over a valid/ready interface and buffers them in a small FIFO. Frames each word into a byte packet: header, four data bytes LSB first, optional XOR checksum. Issues the bytes one at a time to the transmitter's DV/byte inputs, using its active/done outputs for pacing.

## Interface
- FIFO_DEPTH, 8, word FIFO depth; power of two, ≥2
- HEADER, 8'hA5, first byte of every packet
- CLKS_PER_BIT-independent: no baud parameters here
- i_Clock  in  1  system clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Word  in  32  payload word
- i_Word_Valid  in  1  upstream word valid
- o_Word_Ready  out  1  FIFO can accept; = (count < FIFO_DEPTH)
- o_Tx_DV  out  1  one-cycle byte-valid strobe to transmitter
- o_Tx_Byte  out  8  byte to transmit; stable while o_Tx_DV high
- i_Tx_Active  in  1  transmitter busy
- i_Tx_Done  in  1  transmitter done flag (high for ≥1 cycle after stop bit)
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  words currently buffered
- o_Busy  out  1  high whenever state ≠ IDLE
- o_Pkt_Done  out  1  one-cycle pulse when the last byte of a packet completes

## Operation
- Push: i_Word_Valid && o_Word_Ready writes i_Word at wr_ptr. The FIFO is full when count == FIFO_DEPTH, and o_Word_Ready is then low. There is no bypass; a same-cycle pop does not raise ready in that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is updated as +1 on push only, -1 on pop only, unchanged on both.
- States: IDLE, SEND, WAIT_DONE, WAIT_CLR.
- IDLE: pops when count>0 && !i_Tx_Active && !i_Tx_Done. The popped word goes to a shift register, byte index = 0, next state SEND.
- SEND: o_Tx_DV=1 for exactly one cycle; o_Tx_Byte = current byte; → WAIT_DONE.
- WAIT_DONE: holds until i_Tx_Done==1; → WAIT_CLR.
- WAIT_CLR: holds until i_Tx_Done==0 && !i_Tx_Active. This guards against the transmitter's multi-cycle done and cleanup states. Then:
  - If the byte was not the last one, increment the index → SEND.
  - If it was the last one, pulse o_Pkt_Done → IDLE.
- Byte order: index 0 = HEADER, 1..4 = word[7:0], [15:8], [23:16], [31:24], 5 = checksum (only if enabled).
- Checksum = word[7:0]^word[15:8]^word[23:16]^word[31:24]. It is computed at pop and registered.
- Reset (any state, mid-packet included):
  - FIFO is emptied, state → IDLE, partial packet discarded.
  - A byte already handed to the transmitter finishes there.
  - The IDLE guard blocks the next packet until the transmitter is idle with done low.
- Reset values: o_Tx_DV=0, o_Tx_Byte=0, o_Word_Ready=1, o_Fifo_Count=0, o_Busy=0, o_Pkt_Done=0.

## Timing
- All outputs are registered except o_Word_Ready and o_Fifo_Count, which are combinational from the count register.
- Word accepted in cycle N with FIFO empty and transmitter idle: pop at N+1, header o_Tx_DV at N+2.
- Inter-byte gap: o_Tx_DV fires two cycles after the WAIT_CLR exit condition is first seen (one cycle for the WAIT_CLR→SEND transition, one for the registered strobe).
- Back-to-back packets: the next pop happens in the first IDLE cycle after o_Pkt_Done.
- o_Tx_DV is never asserted while i_Tx_Active or i_Tx_Done is high.

## Configuration
- UART_TX_PKT_CHECKSUM_EN defined: packets are 6 bytes (header, 4 data, checksum).
- Not defined: packets are 5 bytes, with no checksum register or logic. o_Pkt_Done follows byte index 4.

## Test plan
- Single word 0x12345678 with checksum enabled and a transmitter model → bytes A5,78,56,34,12,08 in order.
  - Exactly one o_Tx_DV per byte.
  - o_Pkt_Done pulses once.
- Push 9 words with FIFO_DEPTH=8 while the transmitter is stalled:
  - o_Word_Ready drops after the 8th; the 9th is held.
  - o_Fifo_Count=8.
  - On drain, all 8 packets emerge in FIFO order.
- Transmitter model holding done high for 2 cycles → no o_Tx_DV while i_Tx_Done=1.
- Assert i_Reset during byte 2 of a packet with 3 words queued:
  - Next cycle: count=0, o_Busy=0, o_Tx_DV=0.
  - A new word 0x0000_00FF afterwards produces A5,FF,00,00,00,FF.
- Simultaneous push and pop at count=3 → count stays 3 and the data order is preserved across pointer wrap.
- Checksum macro undefined, word 0xDEADBEEF → EF? No: bytes A5,EF,BE,AD,DE only, o_Pkt_Done after DE.
